boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/soc_pkg.sv | 29 ++
 rtl/boot_loader.sv | 143 ++++++++++++++
 tb/tb_boot_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared SoC definitions: word width, boot ROM geometry and boot loader state encoding.
package soc_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned ROM_AW         = 5;
    localparam int unsigned BOOT_ROM_WORDS = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ROM_AW-1:0] rom_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } boot_state_e;

    // Copy-in-progress states; drives the busy flag.
    function automatic logic state_is_busy(input boot_state_e s);
        return (s == ST_READ) || (s == ST_CAPT) || (s == ST_WRITE);
    endfunction

    // ROM fetch states; drives the ROM chip select.
    function automatic logic state_is_fetch(input boot_state_e s);
        return (s == ST_READ) || (s == ST_CAPT);
    endfunction

endpackage

// File: rtl/boot_loader.sv
// Boot loader: copies ROM_WORDS words from boot ROM into RAM at reset release or on start,
// keeping the CPU held until the copy is complete and accumulating a 16-bit checksum.
module boot_loader
    import soc_pkg::*;
#(
    parameter int unsigned        ROM_WORDS = BOOT_ROM_WORDS,
    parameter int unsigned        RAM_AW    = 12,
    parameter logic [RAM_AW-1:0]  RAM_BASE  = RAM_AW'(12'h000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rom_cs,
    output logic              rom_we,
    output logic [4:0]        rom_addr,
    input  logic [15:0]       rom_dout,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic              ram_ready,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    localparam rom_addr_t LAST_IDX = ROM_AW'(ROM_WORDS - 1);

    boot_state_e state_q, state_d;
    rom_addr_t   idx_q, idx_d;
    word_t       buf_q, buf_d;
    word_t       cks_d;

    logic              rom_cs_d;
    rom_addr_t         rom_addr_d;
    logic              ram_cs_d;
    logic              ram_we_d;
    logic [RAM_AW-1:0] ram_addr_d;
    word_t             ram_din_d;
    logic              cpu_hold_d;
    logic              busy_d;
    logic              done_d;

    // The ROM is read-only from this block.
    assign rom_we = 1'b0;

    // State and registered outputs; outputs are computed from next-state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            buf_q    <= '0;
            checksum <= '0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            checksum <= cks_d;
            rom_cs   <= rom_cs_d;
            rom_addr <= rom_addr_d;
            ram_cs   <= ram_cs_d;
            ram_we   <= ram_we_d;
            ram_addr <= ram_addr_d;
            ram_din  <= ram_din_d;
            cpu_hold <= cpu_hold_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next-state, word index, capture buffer and checksum.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        cks_d   = checksum;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_READ;
                idx_d   = '0;
                cks_d   = '0;
            end
            ST_READ: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                buf_d   = rom_dout;
                cks_d   = checksum + rom_dout;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (ram_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ROM_AW'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                    cks_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state; WRITE holds address/data stable while stalled.
    always_comb begin
        rom_cs_d   = state_is_fetch(state_d);
        rom_addr_d = idx_d;
        ram_cs_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = '0;
        ram_din_d  = '0;
        busy_d     = state_is_busy(state_d);
        done_d     = (state_d == ST_DONE);
        cpu_hold_d = (state_d != ST_DONE);
        if (state_d == ST_WRITE) begin
            ram_cs_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = RAM_BASE + RAM_AW'(idx_d);
            ram_din_d  = buf_d;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: cycle-by-cycle vector table plus copy, stall, reset and restart sequences.
module tb_boot_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ready1;
    logic        ready2;

    logic        rom_cs1, rom_we1, ram_cs1, ram_we1, hold1, busy1, done1;
    logic [4:0]  rom_addr1;
    logic [15:0] rom_dout1, ram_din1, cks1;
    logic [11:0] ram_addr1;

    logic        rom_cs2, rom_we2, ram_cs2, ram_we2, hold2, busy2, done2;
    logic [4:0]  rom_addr2;
    logic [15:0] rom_dout2, ram_din2, cks2;
    logic [11:0] ram_addr2;

    int total = 0;
    int bad   = 0;
    int exp1 = 0, exp2 = 0;
    int copies1 = 0, copies2 = 0;

    boot_loader #(.ROM_WORDS(32), .RAM_AW(12), .RAM_BASE(12'h000)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_cs(rom_cs1), .rom_we(rom_we1), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
        .ram_cs(ram_cs1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
        .ram_ready(ready1), .cpu_hold(hold1), .busy(busy1), .done(done1), .checksum(cks1)
    );

    boot_loader #(.ROM_WORDS(32), .RAM_AW(12), .RAM_BASE(12'h100)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_cs(rom_cs2), .rom_we(rom_we2), .rom_addr(rom_addr2), .rom_dout(rom_dout2),
        .ram_cs(ram_cs2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2),
        .ram_ready(ready2), .cpu_hold(hold2), .busy(busy2), .done(done2), .checksum(cks2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous boot ROMs: word i = i * 16'h0101, data one cycle after select.
    always @(posedge clk) if (rom_cs1) rom_dout1 <= 16'(rom_addr1) * 16'h0101;
    always @(posedge clk) if (rom_cs2) rom_dout2 <= 16'(rom_addr2) * 16'h0101;

    // RAM write monitors: each accepted write must be the next word at the next address.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp1 = 0;
        end else begin
            total++;
            if (rom_we1 !== 1'b0) begin
                bad++;
                $display("FAIL rom_we1 got=%b want=0", rom_we1);
            end
            if (ram_cs1 && ram_we1 && ready1) begin
                total++;
                if (ram_addr1 !== 12'(exp1) || ram_din1 !== 16'(exp1) * 16'h0101) begin
                    bad++;
                    $display("FAIL wr1 got addr=%h data=%h want addr=%h data=%h",
                             ram_addr1, ram_din1, 12'(exp1), 16'(exp1) * 16'h0101);
                end
                exp1++;
                if (exp1 == 32) begin
                    exp1 = 0;
                    copies1++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp2 = 0;
        end else begin
            total++;
            if (rom_we2 !== 1'b0 || hold2 !== ~done2) begin
                bad++;
                $display("FAIL hold2/rom_we2 got hold=%b we=%b want hold=%b we=0", hold2, rom_we2, ~done2);
            end
            if (ram_cs2 && ram_we2 && ready2) begin
                total++;
                if (ram_addr2 !== 12'h100 + 12'(exp2) || ram_din2 !== 16'(exp2) * 16'h0101) begin
                    bad++;
                    $display("FAIL wr2 got addr=%h data=%h want addr=%h data=%h",
                             ram_addr2, ram_din2, 12'h100 + 12'(exp2), 16'(exp2) * 16'h0101);
                end
                exp2++;
                if (exp2 == 32) begin
                    exp2 = 0;
                    copies2++;
                end
            end
        end
    end

    typedef struct packed {
        logic        rom_cs;
        logic [4:0]  rom_addr;
        logic        ram_cs;
        logic        ram_we;
        logic [11:0] ram_addr;
        logic [15:0] ram_din;
        logic        busy;
        logic        done;
        logic        hold;
        logic [15:0] cks;
    } obs_t;

    typedef struct {
        logic start;
        logic ready;
        obs_t exp;
    } vec_t;

    function automatic obs_t mk(input logic rc, input logic [4:0] ra, input logic wc,
                                input logic [11:0] wa, input logic [15:0] wd, input logic b,
                                input logic d, input logic h, input logic [15:0] c);
        obs_t o;
        o.rom_cs = rc; o.rom_addr = ra; o.ram_cs = wc; o.ram_we = wc; o.ram_addr = wa;
        o.ram_din = wd; o.busy = b; o.done = d; o.hold = h; o.cks = c;
        return o;
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o.rom_cs = rom_cs1; o.rom_addr = rom_addr1; o.ram_cs = ram_cs1; o.ram_we = ram_we1;
        o.ram_addr = ram_addr1; o.ram_din = ram_din1; o.busy = busy1; o.done = done1;
        o.hold = hold1; o.cks = cks1;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Runs one copy to DONE, optionally stalling one word's write; checks latency, hold and checksum.
    task automatic run_copy(input int stall_word, input int stall_len, input int exp_lat);
        int c0 = -1;
        int lat = -1;
        int n = 0;
        bit stalled = 0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (cyc == 1) chk("first_cycle_hold_busy_done", {hold1, busy1, done1}, 3'b110);
            if (busy1 && c0 < 0) c0 = cyc;
            if (n > 0) begin
                chk("stall_stable", {ram_cs1, ram_addr1, ram_din1}, {1'b1, 12'(stall_word), 16'(stall_word) * 16'h0101});
                n--;
                if (n == 0) ready1 = 1'b1;
            end else if (stall_len > 0 && !stalled && ram_cs1 && ram_addr1 == 12'(stall_word)) begin
                stalled = 1;
                n = stall_len;
                ready1 = 1'b0;
            end
            if (done1) begin
                lat = cyc - c0;
                break;
            end
        end
        chk("copy_latency", 64'(lat), 64'(exp_lat));
        chk("final_checksum", {48'h0, cks1}, {48'h0, 16'hF1F0});
    endtask

    vec_t vecs[11];
    obs_t rst_obs;
    bit   found;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        ready1 = 1'b1;
        ready2 = 1'b1;
        rst_obs = mk(0, 5'd0, 0, 12'h000, 16'h0000, 0, 0, 1, 16'h0000);

        vecs[0]  = '{0, 1, mk(1, 5'd0, 0, 12'h000, 16'h0000, 1, 0, 1, 16'h0000)};
        vecs[1]  = '{0, 1, mk(1, 5'd0, 0, 12'h000, 16'h0000, 1, 0, 1, 16'h0000)};
        vecs[2]  = '{0, 1, mk(0, 5'd0, 1, 12'h000, 16'h0000, 1, 0, 1, 16'h0000)};
        vecs[3]  = '{0, 1, mk(1, 5'd1, 0, 12'h000, 16'h0000, 1, 0, 1, 16'h0000)};
        vecs[4]  = '{0, 1, mk(1, 5'd1, 0, 12'h000, 16'h0000, 1, 0, 1, 16'h0000)};
        vecs[5]  = '{0, 1, mk(0, 5'd1, 1, 12'h001, 16'h0101, 1, 0, 1, 16'h0101)};
        vecs[6]  = '{0, 0, mk(0, 5'd1, 1, 12'h001, 16'h0101, 1, 0, 1, 16'h0101)};
        vecs[7]  = '{0, 0, mk(0, 5'd1, 1, 12'h001, 16'h0101, 1, 0, 1, 16'h0101)};
        vecs[8]  = '{0, 1, mk(1, 5'd2, 0, 12'h000, 16'h0000, 1, 0, 1, 16'h0101)};
        vecs[9]  = '{1, 1, mk(1, 5'd2, 0, 12'h000, 16'h0000, 1, 0, 1, 16'h0101)};
        vecs[10] = '{0, 1, mk(0, 5'd2, 1, 12'h002, 16'h0202, 1, 0, 1, 16'h0303)};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'(obs1()), 64'(rst_obs));
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle-by-cycle table from reset release: first words, a two-cycle stall, start ignored while busy.
        for (int i = 0; i < 11; i++) begin
            start  = vecs[i].start;
            ready1 = vecs[i].ready;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 64'(obs1()), 64'(vecs[i].exp));
        end
        start  = 1'b0;
        ready1 = 1'b1;

        // Reset asserted during word 12's write: immediate reset values, then full restart.
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (ram_cs1 && ram_addr1 == 12'd12) begin
                found = 1;
                break;
            end
        end
        chk("reach_word12", 64'(found), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", 64'(obs1()), 64'(rst_obs));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_copy(0, 0, 96);
        chk("copies_after_reset", 64'(copies1), 64'd1);

        // DONE holds with start low.
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", 64'(obs1()), 64'(mk(0, 5'd31, 0, 12'h000, 16'h0000, 0, 1, 0, 16'hF1F0)));

        // Restart from DONE with a five-cycle RAM stall at word 7.
        start = 1'b1;
        run_copy(7, 5, 101);
        chk("copies_after_restart", 64'(copies1), 64'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("dut2_done", {63'h0, done2}, 64'd1);
        chk("dut2_checksum", {48'h0, cks2}, {48'h0, 16'hF1F0});
        chk("dut2_copies", 64'(copies2), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
